// File: rtl/aes_decipher_block.sv
// Iterative AES-128/256 block decipher: one shared 32-bit inverse S-box,
// one state word substituted per cycle, round keys fetched by index.
// Ports: clk, rst (sync, active-high), next/keylen/block (start request),
// round_key (in) / round (out) key-memory lookup, new_block, ready.

module aes_inv_sbox (
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; zero maps to zero.
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
        x2   = gmul(x, x);
        x3   = gmul(x2, x);
        x6   = gmul(x3, x3);
        x12  = gmul(x6, x6);
        x15  = gmul(x12, x3);
        x30  = gmul(x15, x15);
        x60  = gmul(x30, x30);
        x120 = gmul(x60, x60);
        x240 = gmul(x120, x120);
        x252 = gmul(x240, x12);
        return gmul(x252, x2);
    endfunction

    // Undo the affine transform first, then invert in GF(2^8).
    function automatic logic [7:0] inv_sub(input logic [7:0] c);
        logic [7:0] b;
        b = {c[6:0], c[7]} ^ {c[4:0], c[7:5]} ^ {c[1:0], c[7:2]} ^ 8'h05;
        return ginv(b);
    endfunction

    assign word_out = {inv_sub(word_in[31:24]), inv_sub(word_in[23:16]),
                       inv_sub(word_in[15:8]),  inv_sub(word_in[7:0])};
endmodule

module aes_decipher_block #(
    parameter bit USE_256 = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         next,
    input  logic         keylen,
    input  logic [127:0] block,
    input  logic [127:0] round_key,
    output logic [3:0]   round,
    output logic [127:0] new_block,
    output logic         ready
);
    typedef enum logic [2:0] {IDLE, INIT, SHIFT, SBOX, MAIN} state_t;

    state_t       state, state_n;
    logic [127:0] block_reg, block_n;
    logic [3:0]   round_ctr, rctr_n;
    logic [1:0]   word_ctr, wctr_n;
    logic         keylen_reg, klen_n;
    logic         ready_reg, ready_n;
    logic [3:0]   nr;
    logic [6:0]   base;
    logic [31:0]  sbox_in, sbox_out;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] m9 [4], mb [4], md [4], me [4];
        logic [7:0] x2, x4, x8;
        for (int r = 0; r < 4; r++) begin
            a[r]  = c[31-8*r -: 8];
            x2    = xt(a[r]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[r] = x8 ^ a[r];
            mb[r] = x8 ^ x2 ^ a[r];
            md[r] = x8 ^ x4 ^ a[r];
            me[r] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
                inv_mix_col(s[63:32]),  inv_mix_col(s[31:0])};
    endfunction

    // Row r of column c comes from column (c - r) mod 4.
    function automatic logic [127:0] inv_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-32*c-8*r -: 8] = s[127-32*((c-r+4)%4)-8*r -: 8];
        return o;
    endfunction

    assign nr      = keylen_reg ? 4'd14 : 4'd10;
    // Word w sits at bit offset (3-w)*32.
    assign base    = {~word_ctr, 5'd0};
    assign sbox_in = block_reg[base +: 32];

    aes_inv_sbox u_inv_sbox (
        .word_in (sbox_in),
        .word_out(sbox_out)
    );

    assign round = (state == IDLE) ? 4'd0 :
                   (state == INIT) ? nr : round_ctr;
    assign new_block = block_reg;
    assign ready     = ready_reg;

    always_comb begin
        state_n = state;
        block_n = block_reg;
        rctr_n  = round_ctr;
        wctr_n  = word_ctr;
        klen_n  = keylen_reg;
        ready_n = ready_reg;
        unique case (state)
            IDLE: begin
                if (next) begin
                    block_n = block;
                    klen_n  = keylen & USE_256;
                    ready_n = 1'b0;
                    state_n = INIT;
                end
            end
            INIT: begin
                block_n = block_reg ^ round_key;
                rctr_n  = nr - 4'd1;
                state_n = SHIFT;
            end
            SHIFT: begin
                block_n = inv_shift(block_reg);
                wctr_n  = 2'd0;
                state_n = SBOX;
            end
            SBOX: begin
                block_n[base +: 32] = sbox_out;
                wctr_n = word_ctr + 2'd1;
                if (word_ctr == 2'd3) state_n = MAIN;
            end
            MAIN: begin
                if (round_ctr != 4'd0) begin
                    block_n = inv_mix(block_reg ^ round_key);
                    rctr_n  = round_ctr - 4'd1;
                    state_n = SHIFT;
                end else begin
                    block_n = block_reg ^ round_key;
                    ready_n = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            block_reg  <= '0;
            round_ctr  <= '0;
            word_ctr   <= '0;
            keylen_reg <= 1'b0;
            ready_reg  <= 1'b1;
        end else begin
            state      <= state_n;
            block_reg  <= block_n;
            round_ctr  <= rctr_n;
            word_ctr   <= wctr_n;
            keylen_reg <= klen_n;
            ready_reg  <= ready_n;
        end
    end
endmodule

// File: tb/tb_aes_decipher_block.sv
// Scoreboard bench for aes_decipher_block: FIPS-197 vectors, back-to-back,
// ignored start, mid-run reset, and a USE_256=0 instance.

module tb_aes_decipher_block;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         next_v   [2];
    logic         keylen_v [2];
    logic [127:0] block_v  [2];
    logic [127:0] rk_v     [2];
    logic [3:0]   round_v  [2];
    logic [127:0] nb_v     [2];
    logic         ready_v  [2];
    int           kset     [2];
    logic [127:0] rk [3][15];

    assign rk_v[0] = rk[kset[0]][round_v[0]];
    assign rk_v[1] = rk[kset[1]][round_v[1]];

    aes_decipher_block #(.USE_256(1'b1)) dut (
        .clk(clk), .rst(rst), .next(next_v[0]), .keylen(keylen_v[0]),
        .block(block_v[0]), .round_key(rk_v[0]), .round(round_v[0]),
        .new_block(nb_v[0]), .ready(ready_v[0]));

    aes_decipher_block #(.USE_256(1'b0)) dut128 (
        .clk(clk), .rst(rst), .next(next_v[1]), .keylen(keylen_v[1]),
        .block(block_v[1]), .round_key(rk_v[1]), .round(round_v[1]),
        .new_block(nb_v[1]), .ready(ready_v[1]));

    localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C3_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;

    // ---- reference key schedule ----
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] y = 8'h01;
        logic [7:0] b;
        for (int k = 0; k < 254; k++) y = gmul(y, x);
        b = (x == 8'h00) ? 8'h00 : y;
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic void expand(input int set, input logic [255:0] key,
                                   input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        int          nrr = nk + 6;
        for (int r = 0; r < 15; r++) rk[set][r] = '0;
        for (int i = 0; i < 4 * (nrr + 1); i++) begin
            if (i < nk) w[i] = key[255-32*i -: 32];
            else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = xtime(rc);
                end else if (nk > 6 && i % nk == 4) t = subword(t);
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int r = 0; r <= nrr; r++)
            rk[set][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    // ---- scoreboard ----
    typedef struct {
        logic [127:0] pt;
        int           nr;
    } exp_t;

    exp_t sbq [2][$];
    bit   busy [2];
    int   cnt  [2];
    bit   rst_prev = 1'b0;
    bit   done = 1'b0;
    bit   fin  = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always @(negedge clk) begin
        exp_t e;
        int   er;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                if (busy[i] && sbq[i].size() > 0) void'(sbq[i].pop_front());
                busy[i] = 1'b0;
                cnt[i]  = 0;
            end else if (rst_prev) begin
                checks += 3;
                if (ready_v[i] !== 1'b1) begin
                    errors++;
                    $display("FAIL rst_ready dut%0d got %b want 1", i, ready_v[i]);
                end
                if (nb_v[i] !== 128'h0) begin
                    errors++;
                    $display("FAIL rst_block dut%0d got %h want 0", i, nb_v[i]);
                end
                if (round_v[i] !== 4'd0) begin
                    errors++;
                    $display("FAIL rst_round dut%0d got %0d want 0", i, round_v[i]);
                end
            end else if (ready_v[i] !== 1'b1) begin
                busy[i] = 1'b1;
                cnt[i]++;
                checks++;
                if (sbq[i].size() == 0) begin
                    if (cnt[i] == 1) begin
                        errors++;
                        $display("FAIL spurious_start dut%0d got busy want idle", i);
                    end else checks--;
                end else begin
                    er = (cnt[i] == 1) ? sbq[i][0].nr
                                       : sbq[i][0].nr - 1 - (cnt[i] - 2) / 6;
                    if (int'(round_v[i]) != er) begin
                        errors++;
                        $display("FAIL round dut%0d cyc %0d got %0d want %0d",
                                 i, cnt[i], round_v[i], er);
                    end
                end
                if (cnt[i] > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL timeout dut%0d got %0d busy cycles want <=200",
                             i, cnt[i]);
                    if (sbq[i].size() > 0) void'(sbq[i].pop_front());
                    busy[i] = 1'b0;
                    cnt[i]  = 0;
                end
            end else if (busy[i]) begin
                busy[i] = 1'b0;
                checks++;
                if (sbq[i].size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done dut%0d got %h want none", i, nb_v[i]);
                end else begin
                    e = sbq[i].pop_front();
                    checks++;
                    if (nb_v[i] !== e.pt) begin
                        errors++;
                        $display("FAIL plaintext dut%0d got %h want %h", i, nb_v[i], e.pt);
                    end
                    if (cnt[i] != 1 + 6 * e.nr) begin
                        errors++;
                        $display("FAIL latency dut%0d got %0d want %0d",
                                 i, cnt[i], 1 + 6 * e.nr);
                    end
                end
                cnt[i] = 0;
            end
        end
        rst_prev = rst;
        if (done && !fin) begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (sbq[i].size() != 0) begin
                    errors++;
                    $display("FAIL pending dut%0d got %0d want 0", i, sbq[i].size());
                end
            end
            fin = 1'b1;
        end
    end

    // ---- stimulus ----
    task automatic start(input int i, input logic [127:0] ct, input bit kl,
                         input int ks, input logic [127:0] pt, input int nr);
        exp_t e;
        e.pt = pt;
        e.nr = nr;
        sbq[i].push_back(e);
        block_v[i]  = ct;
        keylen_v[i] = kl;
        kset[i]     = ks;
        next_v[i]   = 1'b1;
        @(posedge clk);
        #1;
        next_v[i]   = 1'b0;
        block_v[i]  = ~ct;
        keylen_v[i] = ~kl;
    endtask

    task automatic wait_ready(input int i);
        for (int k = 0; k < 250; k++) begin
            @(posedge clk);
            #1;
            if (ready_v[i]) break;
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            next_v[i] = 1'b0; keylen_v[i] = 1'b0;
            block_v[i] = '0; kset[i] = 0;
        end
        expand(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
        expand(1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
        expand(2, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        start(0, C1_CT, 1'b0, 0, C_PT, 10);
        wait_ready(0);
        start(0, C3_CT, 1'b1, 1, C_PT, 14);
        wait_ready(0);

        start(0, B_CT, 1'b0, 2, B_PT, 10);
        wait_ready(0);
        start(0, C1_CT, 1'b0, 0, C_PT, 10);
        wait_ready(0);

        start(0, C1_CT, 1'b0, 0, C_PT, 10);
        repeat (19) @(posedge clk);
        #1;
        next_v[0] = 1'b1; block_v[0] = B_CT; keylen_v[0] = 1'b1;
        @(posedge clk);
        #1 next_v[0] = 1'b0;
        wait_ready(0);

        start(0, B_CT, 1'b0, 2, B_PT, 10);
        repeat (29) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        start(0, C3_CT, 1'b1, 1, C_PT, 14);
        wait_ready(0);

        start(1, C1_CT, 1'b1, 0, C_PT, 10);
        wait_ready(1);

        repeat (2) @(posedge clk);
        done = 1'b1;
        for (int k = 0; k < 10 && !fin; k++) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/aes_decipher_block.md
Name: aes_decipher_block

Overview:
- Iterative AES block decipher core consuming the 32-bit combinational inverse S-box. It instantiates one inverse S-box internally and shares it across the four state words, one word per cycle.
- Takes a 128-bit ciphertext and per-round keys from an external key memory. Produces the 128-bit plaintext for AES-128 or AES-256.
- Sits between the AES top-level control/key-expansion logic and the inverse S-box.

Parameters:
- USE_256, default 1: 1 = keylen honoured; 0 = keylen ignored, core always runs AES-128.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- next  in  1  start pulse; honoured only when ready=1.
- keylen  in  1  0 = AES-128 (Nr=10), 1 = AES-256 (Nr=14); sampled with next.
- block  in  128  ciphertext; sampled with next.
- round_key  in  128  key for the index on round; must be valid combinationally in the same cycle.
- round  out  4  round-key index requested.
- new_block  out  128  state register; holds the plaintext when ready=1 after a run.
- ready  out  1  1 = idle / result valid.

Behaviour:
- Byte/word order:
  - Word w0 = bits[127:96] … w3 = bits[31:0], each a column.
  - Byte [31:24] of a word is row 0.
  - InvShiftRows rotates row i right by i columns.
  - InvMixColumns uses the standard {0e,0b,0d,09} matrix over GF(2^8) with poly 0x11b.
- Reset (rst=1 at an edge, any state, including mid-operation):
  - state=IDLE, ready=1, new_block=0, round=0, word counter=0, stored keylen=0.
  - Any operation in progress is aborted with no partial result.
- FSM states: IDLE, INIT, SHIFT, SBOX, MAIN.
- IDLE:
  - round=0.
  - If next=1 at edge T: block_reg<=block, Nr latched from keylen, ready<=0, state<=INIT.
  - next=0: hold.
- INIT (1 cycle):
  - round=Nr; block_reg<=block_reg^round_key.
  - Round counter<=Nr-1; state<=SHIFT.
- SHIFT (1 cycle): block_reg<=InvShiftRows(block_reg); word counter<=0; state<=SBOX.
- SBOX (4 cycles, counter 0..3):
  - Word[counter] is driven to the inverse S-box; result is written back to the same word only.
  - Counter increments; after counter=3, state<=MAIN.
- MAIN (1 cycle), round=r:
  - If r>0: block_reg<=InvMixColumns(block_reg^round_key); r<=r-1; state<=SHIFT.
  - If r=0: block_reg<=block_reg^round_key; ready<=1; state<=IDLE.
- round output: equals the current round counter in SHIFT/SBOX/MAIN, Nr in INIT, 0 in IDLE.
- Latency: next sampled at edge T → ready=1 and plaintext valid after edge T+1+6·Nr.
  - AES-128: 61 busy cycles.
  - AES-256: 85 busy cycles.
- next while ready=0: ignored, with no effect on state, round or keylen.
- next asserted in the same cycle ready rises: accepted. Back-to-back operation is allowed with no idle gap.
- block/keylen changes while busy: no effect.
- new_block:
  - Continuously reflects block_reg; intermediate values are visible while busy and are not valid.
  - Holds the result until the next accepted start or reset.
- USE_256=0: Nr=10 regardless of keylen.

Test Plan:
- AES-128, FIPS-197 C.1, key 000102…0f, bench-model round keys. block=69c4e0d86a7b0430d8cdb78070b4c55a, next pulse → ready low for 61 cycles, then new_block=00112233445566778899aabbccddeeff.
- AES-256, FIPS-197 C.3, key 000102…1f. block=8ea2b7ca516745bfeafc49904b496089 → new_block=00112233445566778899aabbccddeeff after 85 busy cycles. round must step 14,13,…,0.
- AES-128, FIPS-197 App. B, key 2b7e151628aed2a6abf7158809cf4f3c. block=3925841d02dc09fbdc118597196a0b32 → 3243f6a8885a308d313198a2e0370734. Immediately re-pulse next in the ready-rise cycle with the C.1 vector → second result correct, no idle gap.
- Pulse next with a different block at busy cycle 20 → ignored; result equals the first vector's plaintext.
- Assert rst at busy cycle 30 → the next cycle shows ready=1, new_block=0, round=0. A fresh run then completes correctly.
- USE_256=0 build, keylen=1 with the C.1 AES-128 vector → 61-cycle run, correct AES-128 plaintext.
